traffic_monitor: RTL and testbench
==================================

TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 Parameter GREEN_CYC, default 8: required green dwell per direction, in clk cycles.
REQ-002 Parameter YELLOW_CYC, default 4: required yellow dwell per direction, in clk cycles.
REQ-003 Parameter ALLRED_MAX, default 2: maximum consecutive all-red cycles permitted between phases.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_a  input  1  reset, asynchronous, active-low.
REQ-006 n_lights, s_lights, e_lights, w_lights  input  3 each  observed light buses; GREEN=001, YELLOW=010, RED=100.
REQ-007 fault  output  1  sticky fault flag.
REQ-008 fault_code  output  3  code of the first fault: 0 none, 1 encoding, 2 conflict, 3 sequence, 4 timing, 5 stall.
REQ-009 active_dir  output  2  tracked direction: N=0, S=1, E=2, W=3.
REQ-010 phase_cnt  output  4  cycles elapsed in the current green/yellow phase; 1 on the first cycle of the phase.
REQ-011 rotations  output  8  completed N->S->E->W rotations; saturates at 255.

Function
REQ-012 The monitor SHALL sample all four buses every cycle and register its results; fault/fault_code SHALL assert on the cycle after the offending sample.
REQ-013 FSM states: SYNC, GREEN, YELLOW, GAP, FAULT.
REQ-014 Encoding check (all states): any bus not in {001,010,100} -> code 1.
REQ-015 Conflict check (all states): more than one bus non-red in the same cycle -> code 2.
REQ-016 SYNC: wait for exactly one bus non-red. If it is green, go to GREEN with that active_dir and an untimed first phase. If it is yellow, go to YELLOW, also untimed. Stall is not checked in SYNC.
REQ-017 GREEN: the same bus green increments phase_cnt. Exceeding GREEN_CYC -> code 4.
REQ-018 GREEN exit: the same bus going yellow -> YELLOW with phase_cnt=1; any other change -> code 3.
REQ-019 GREEN exit timing: on exit, phase_cnt != GREEN_CYC (timed phase only) -> code 4.
REQ-020 YELLOW: the same bus yellow increments phase_cnt. Exceeding YELLOW_CYC -> code 4.
REQ-021 YELLOW exit: all-red -> GAP. Next direction (active_dir+1 mod 4) green -> GREEN directly. Any other pattern -> code 3.
REQ-022 YELLOW exit timing: on exit, phase_cnt != YELLOW_CYC (timed phase only) -> code 4.
REQ-023 GAP: the next direction green -> GREEN (timed). Any other non-red bus -> code 3. All-red for more than ALLRED_MAX cycles -> code 5.
REQ-024 On entering GREEN for N from W, rotations SHALL increment by 1, saturating at 255.
REQ-025 Simultaneous faults SHALL be prioritised 1 > 2 > 3 > 4 > 5.
REQ-026 The first fault SHALL latch: enter FAULT, hold fault=1 and fault_code until reset, and freeze active_dir, phase_cnt and rotations.
REQ-027 phase_cnt SHALL saturate at 15.
REQ-028 phase_cnt SHALL read 0 in SYNC and GAP.

Reset
REQ-029 rst_a low SHALL asynchronously force state=SYNC, fault=0, fault_code=0, active_dir=0, phase_cnt=0, rotations=0.
REQ-030 Reset asserted mid-phase or in FAULT SHALL discard all history.
REQ-031 After reset is released, operation SHALL resume from SYNC.

Structure
REQ-032 Shared package traffic_pkg SHALL hold: the light encodings (GREEN/YELLOW/RED), the direction codes, the fault codes, and the FSM state encoding. The controller SHALL use the same package.
REQ-033 One sub-module, light_decode (combinational), SHALL map a 3-bit bus to {is_green, is_yellow, is_red, illegal}. It SHALL be instantiated four times.
REQ-034 Target size: 150-300 lines RTL.

Verification
REQ-035 Release rst_a at t=15. Drive the legal cycle N green 8 / N yellow 4 / S green 8 / ... for 2 rotations -> fault=0 throughout, rotations=2.
REQ-036 During a timed N green, drive S=001 for one cycle -> next cycle fault=1, fault_code=2. Both stay held for 20 further cycles.
REQ-037 Drive E=011 in any state -> fault_code=1. Drive E=011 and N,S both green in the same cycle -> fault_code=1 (priority).
REQ-038 Timed S green lasting 7 cycles then S yellow -> fault_code=4. Timed S green lasting 9 cycles -> fault_code=4 in the cycle after the 9th sample.
REQ-039 After N yellow, drive E green -> fault_code=3. After N yellow, drive all-red for 3 cycles -> fault_code=5 after the 3rd all-red cycle.
REQ-040 Assert rst_a low during FAULT -> all outputs 0 immediately. After release, a legal sequence produces no fault.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light monitor: light codes, direction codes,
// fault codes, monitor FSM states and the per-bus decode record.
package traffic_pkg;

  localparam int NUM_DIR = 4;

  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_RED    = 3'b100;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [2:0] F_NONE     = 3'd0;
  localparam logic [2:0] F_ENC      = 3'd1;
  localparam logic [2:0] F_CONFLICT = 3'd2;
  localparam logic [2:0] F_SEQ      = 3'd3;
  localparam logic [2:0] F_TIMING   = 3'd4;
  localparam logic [2:0] F_STALL    = 3'd5;

  localparam logic [2:0] ST_SYNC   = 3'd0;
  localparam logic [2:0] ST_GREEN  = 3'd1;
  localparam logic [2:0] ST_YELLOW = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  typedef struct packed {
    logic is_green;
    logic is_yellow;
    logic is_red;
    logic illegal;
  } light_t;

  // Directions rotate N->S->E->W->N, so the successor is a 2-bit wrap.
  function automatic logic [1:0] next_dir(input logic [1:0] d);
    return d + 2'd1;
  endfunction

endpackage

// File: rtl/light_decode.sv
// Combinational decode of one observed 3-bit light bus into one-hot flags.
module light_decode
  import traffic_pkg::*;
(
  input  logic [2:0] bus,
  output logic       is_green,
  output logic       is_yellow,
  output logic       is_red,
  output logic       illegal
);

  assign is_green  = (bus == L_GREEN);
  assign is_yellow = (bus == L_YELLOW);
  assign is_red    = (bus == L_RED);
  assign illegal   = ~(is_green | is_yellow | is_red);

endmodule

// File: rtl/traffic_monitor.sv
// Observes four intersection light buses and latches the first protocol
// violation (encoding, conflict, sequence, timing, all-red stall).
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_MAX = 2
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] n_lights,
  input  logic [2:0] s_lights,
  input  logic [2:0] e_lights,
  input  logic [2:0] w_lights,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] active_dir,
  output logic [3:0] phase_cnt,
  output logic [7:0] rotations
);

  logic [NUM_DIR-1:0][2:0] bus;
  light_t [NUM_DIR-1:0]    lt;

  assign bus = {w_lights, e_lights, s_lights, n_lights};

  for (genvar i = 0; i < NUM_DIR; i++) begin : g_dec
    light_decode u_dec (
      .bus       (bus[i]),
      .is_green  (lt[i].is_green),
      .is_yellow (lt[i].is_yellow),
      .is_red    (lt[i].is_red),
      .illegal   (lt[i].illegal)
    );
  end

  logic       enc_err, all_red, conflict, one_lit;
  logic [2:0] lit_cnt;
  logic [1:0] sole_dir;

  always_comb begin
    enc_err  = 1'b0;
    all_red  = 1'b1;
    lit_cnt  = '0;
    sole_dir = DIR_N;
    for (int i = 0; i < NUM_DIR; i++) begin
      enc_err = enc_err | lt[i].illegal;
      all_red = all_red & lt[i].is_red;
      if (lt[i].is_green | lt[i].is_yellow) begin
        lit_cnt  = lit_cnt + 3'd1;
        sole_dir = 2'(i);
      end
    end
  end

  assign conflict = (lit_cnt > 3'd1);
  assign one_lit  = (lit_cnt == 3'd1);

  logic [2:0] state, st_n, code_st, code_n;
  logic [1:0] dir_n, nxt;
  logic [3:0] cnt_n, cnt_inc;
  logic [7:0] rot_n, rot_inc, gap_cnt, gap_n, gap_inc;
  logic       timed, timed_n, go_green;
  logic       same_g, same_y, next_g, g_exit_bad, y_exit_bad;

  assign nxt        = next_dir(active_dir);
  assign same_g     = one_lit && lt[active_dir].is_green;
  assign same_y     = one_lit && lt[active_dir].is_yellow;
  assign next_g     = one_lit && lt[nxt].is_green;
  assign cnt_inc    = (phase_cnt == 4'hF) ? phase_cnt : phase_cnt + 4'd1;
  assign gap_inc    = (gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1;
  assign rot_inc    = (rotations == 8'hFF) ? rotations : rotations + 8'd1;
  // A phase first seen in SYNC has an unknown start, so its length is not judged.
  assign g_exit_bad = timed && (int'(phase_cnt) != GREEN_CYC);
  assign y_exit_bad = timed && (int'(phase_cnt) != YELLOW_CYC);

  always_comb begin
    st_n     = state;
    dir_n    = active_dir;
    cnt_n    = phase_cnt;
    rot_n    = rotations;
    timed_n  = timed;
    gap_n    = gap_cnt;
    code_st  = F_NONE;
    go_green = 1'b0;
    case (state)
      ST_SYNC: begin
        if (one_lit) begin
          dir_n   = sole_dir;
          cnt_n   = 4'd1;
          timed_n = 1'b0;
          st_n    = lt[sole_dir].is_green ? ST_GREEN : ST_YELLOW;
        end
      end
      ST_GREEN: begin
        if (same_g) begin
          cnt_n = cnt_inc;
          if (timed && int'(cnt_inc) > GREEN_CYC) code_st = F_TIMING;
        end else if (same_y) begin
          st_n    = ST_YELLOW;
          cnt_n   = 4'd1;
          timed_n = 1'b1;
          if (g_exit_bad) code_st = F_TIMING;
        end else begin
          code_st = F_SEQ;
        end
      end
      ST_YELLOW: begin
        if (same_y) begin
          cnt_n = cnt_inc;
          if (timed && int'(cnt_inc) > YELLOW_CYC) code_st = F_TIMING;
        end else if (all_red) begin
          st_n  = ST_GAP;
          cnt_n = 4'd0;
          gap_n = 8'd1;
          if (y_exit_bad) code_st = F_TIMING;
        end else if (next_g) begin
          go_green = 1'b1;
          if (y_exit_bad) code_st = F_TIMING;
        end else begin
          code_st = F_SEQ;
        end
      end
      ST_GAP: begin
        if (all_red) begin
          gap_n = gap_inc;
          if (int'(gap_inc) > ALLRED_MAX) code_st = F_STALL;
        end else if (next_g) begin
          go_green = 1'b1;
        end else begin
          code_st = F_SEQ;
        end
      end
      default: ;
    endcase
    if (go_green) begin
      st_n    = ST_GREEN;
      dir_n   = nxt;
      cnt_n   = 4'd1;
      timed_n = 1'b1;
      if (active_dir == DIR_W) rot_n = rot_inc;
    end
    code_n = enc_err ? F_ENC : (conflict ? F_CONFLICT : code_st);
  end

  // On a fault only the flag and code move; the tracking registers keep the
  // values they held before the offending sample.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state      <= ST_SYNC;
      fault      <= 1'b0;
      fault_code <= F_NONE;
      active_dir <= DIR_N;
      phase_cnt  <= '0;
      rotations  <= '0;
      timed      <= 1'b0;
      gap_cnt    <= '0;
    end else if (state != ST_FAULT) begin
      if (code_n != F_NONE) begin
        state      <= ST_FAULT;
        fault      <= 1'b1;
        fault_code <= code_n;
      end else begin
        state      <= st_n;
        active_dir <= dir_n;
        phase_cnt  <= cnt_n;
        rotations  <= rot_n;
        timed      <= timed_n;
        gap_cnt    <= gap_n;
      end
    end
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// Scoreboard bench for traffic_monitor: directed and randomized light
// sequences checked against a phase-level reference model.
module tb_traffic_monitor;

  localparam int GC = 8;
  localparam int YC = 4;
  localparam int AR = 2;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk, rst_a;
  logic [2:0] n_l, s_l, e_l, w_l;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] active_dir;
  logic [3:0] phase_cnt;
  logic [7:0] rotations;

  traffic_monitor #(.GREEN_CYC(GC), .YELLOW_CYC(YC), .ALLRED_MAX(AR)) dut (
    .clk        (clk),
    .rst_a      (rst_a),
    .n_lights   (n_l),
    .s_lights   (s_l),
    .e_lights   (e_l),
    .w_lights   (w_l),
    .fault      (fault),
    .fault_code (fault_code),
    .active_dir (active_dir),
    .phase_cnt  (phase_cnt),
    .rotations  (rotations)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       f;
    logic [2:0] code;
    logic [1:0] dir;
    logic [3:0] cnt;
    logic [7:0] rot;
  } obs_t;

  obs_t  sb_q[$];
  string tag_q[$];
  string tag;
  int    n_vec = 0;
  int    n_err = 0;

  // Reference model: the phase currently shown (dir + colour, or gap after a
  // yellow), its unbounded run length, and the first fault seen.
  bit m_fault, m_sync, m_timed;
  int m_code, m_dir, m_col, m_run, m_gap, m_rot;  // m_col: 0 green, 1 yellow, 2 gap

  function automatic void model_reset();
    m_fault = 0; m_code = 0; m_sync = 0; m_timed = 0;
    m_dir = 0; m_col = 2; m_run = 0; m_gap = 0; m_rot = 0;
  endfunction

  function automatic void latch(input int code);
    m_fault = 1;
    m_code  = code;
  endfunction

  function automatic void enter_green(input int d);
    if (d == 0) m_rot = (m_rot < 255) ? m_rot + 1 : 255;
    m_dir = d; m_col = 0; m_run = 1; m_timed = 1;
  endfunction

  function automatic void model_step(input logic [2:0] n, s, e, w);
    logic [2:0] b [4];
    int  lit, ld, lcol;
    bit  bad, same, nextg;
    b[0] = n; b[1] = s; b[2] = e; b[3] = w;
    if (m_fault) return;
    bad = 0; lit = 0; ld = 0; lcol = 0;
    for (int i = 0; i < 4; i++) begin
      if (b[i] != G && b[i] != Y && b[i] != R) bad = 1;
      else if (b[i] != R) begin lit++; ld = i; lcol = (b[i] == G) ? 0 : 1; end
    end
    if (bad) begin latch(1); return; end
    if (lit > 1) begin latch(2); return; end
    if (!m_sync) begin
      if (lit == 1) begin m_sync = 1; m_dir = ld; m_col = lcol; m_run = 1; m_timed = 0; end
      return;
    end
    same  = (lit == 1) && (ld == m_dir);
    nextg = (lit == 1) && (ld == (m_dir + 1) % 4) && (lcol == 0);
    case (m_col)
      0: begin
        if (same && lcol == 0) begin
          if (m_timed && m_run + 1 > GC) latch(4); else m_run++;
        end else if (same && lcol == 1) begin
          if (m_timed && m_run != GC) latch(4);
          else begin m_col = 1; m_run = 1; m_timed = 1; end
        end else latch(3);
      end
      1: begin
        if (same && lcol == 1) begin
          if (m_timed && m_run + 1 > YC) latch(4); else m_run++;
        end else if (lit == 0 || nextg) begin
          if (m_timed && m_run != YC) latch(4);
          else if (lit == 0) begin m_col = 2; m_gap = 1; end
          else enter_green((m_dir + 1) % 4);
        end else latch(3);
      end
      default: begin
        if (lit == 0) begin
          if (m_gap + 1 > AR) latch(5); else m_gap++;
        end else if (nextg) enter_green((m_dir + 1) % 4);
        else latch(3);
      end
    endcase
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.f    = m_fault;
    o.code = 3'(m_code);
    o.dir  = 2'(m_dir);
    o.cnt  = (!m_sync || m_col == 2) ? 4'd0 : 4'((m_run > 15) ? 15 : m_run);
    o.rot  = 8'(m_rot);
    return o;
  endfunction

  task automatic drive(input logic [2:0] n, s, e, w);
    @(negedge clk);
    n_l = n; s_l = s; e_l = e; w_l = w;
    model_step(n, s, e, w);
    sb_q.push_back(model_out());
    tag_q.push_back(tag);
  endtask

  task automatic lights(input int d, input logic [2:0] c, input int len);
    logic [2:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = (i == d) ? c : R;
    repeat (len) drive(b[0], b[1], b[2], b[3]);
  endtask

  task automatic allred(input int len);
    repeat (len) drive(R, R, R, R);
  endtask

  function automatic logic [2:0] rand_bus();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic int jitter();
    if ($urandom_range(0, 9) != 0) return 0;
    return ($urandom_range(0, 1) != 0) ? 1 : -1;
  endfunction

  // Monitor: every registered output cycle with a pending expectation.
  initial begin
    obs_t  e, a;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        a = {fault, fault_code, active_dir, phase_cnt, rotations};
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s @%0t: got f=%0d code=%0d dir=%0d cnt=%0d rot=%0d, want f=%0d code=%0d dir=%0d cnt=%0d rot=%0d",
                   t, $time, a.f, a.code, a.dir, a.cnt, a.rot, e.f, e.code, e.dir, e.cnt, e.rot);
        end
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 10) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations still pending, want 0", sb_q.size());
      sb_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if ({fault, fault_code, active_dir, phase_cnt, rotations} !== 18'd0) begin
      n_err++;
      $display("FAIL %s: got f=%0d code=%0d dir=%0d cnt=%0d rot=%0d, want all zero",
               name, fault, fault_code, active_dir, phase_cnt, rotations);
    end
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    #1;
    rst_a = 1'b0;
    n_l = R; s_l = R; e_l = R; w_l = R;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    int d;
    rst_a = 1'b0;
    n_l = R; s_l = R; e_l = R; w_l = R;
    model_reset();
    #12 check_zero("reset_state");
    #3 rst_a = 1'b1;

    tag = "legal_2rot";
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        lights(k, G, GC);
        lights(k, Y, YC);
      end
    tag = "conflict";
    lights(0, G, 3);
    drive(G, G, R, R);
    repeat (20) drive(rand_bus(), rand_bus(), rand_bus(), rand_bus());
    do_reset();

    tag = "post_reset_legal";
    for (int k = 0; k < 5; k++) begin
      lights(k % 4, G, GC);
      lights(k % 4, Y, YC);
      allred(k % (AR + 1));
    end
    do_reset();

    tag = "enc";
    lights(2, G, 3);
    drive(R, R, 3'b011, R);
    allred(2);
    do_reset();
    tag = "enc_prio";
    drive(G, G, 3'b011, R);
    drive(R, R, R, R);
    do_reset();

    tag = "short_green";
    lights(0, G, GC); lights(0, Y, YC);
    lights(1, G, 7); lights(1, Y, 2);
    do_reset();
    tag = "long_green";
    lights(0, G, GC); lights(0, Y, YC);
    lights(1, G, 9); lights(1, Y, 1);
    do_reset();
    tag = "long_yellow";
    lights(0, G, GC); lights(0, Y, YC + 1); allred(1);
    do_reset();

    tag = "seq_after_yellow";
    lights(0, Y, 2); lights(2, G, 2);
    do_reset();
    tag = "stall";
    lights(0, Y, 2); allred(4);
    do_reset();

    tag = "untimed_sat";
    lights(3, G, 18); lights(3, Y, YC); lights(0, G, 2);
    do_reset();

    tag = "fuzz";
    for (int ep = 0; ep < 12; ep++) begin
      d = $urandom_range(0, 3);
      for (int p = 0; p < 10; p++) begin
        lights(d, G, GC + jitter());
        lights(d, Y, YC + jitter());
        allred(($urandom_range(0, 9) == 0) ? AR + 1 : $urandom_range(0, AR));
        if ($urandom_range(0, 19) == 0) drive(rand_bus(), rand_bus(), rand_bus(), rand_bus());
        d = (d + 1) % 4;
      end
      do_reset();
    end

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
